// File: rtl/hex_display_scanner.sv
// Eight-digit multiplexed hex display scanner: latches a 32-bit word and
// time-multiplexes its nibbles onto one active-low 7-segment digit at a time.
// Latency: displayed_data follows the load edge by one cycle. Outputs are
// combinational from registers. No backpressure; the scan is free-running.
//
// Ports:
//   clock, reset       - system clock, synchronous active-high reset
//   display_data       - word to display, loaded when update_enabled=1
//   update_enabled     - load strobe for display_data
//   displayed_data     - currently latched word
//   segments           - active-low segments, [6:0] = g f e d c b a
//   decimal_point      - active-low decimal point (always off)
//   digit_select       - active-low one-hot anode enable, bit i = nibble i
module hex_display_scanner #(
  parameter int DIVIDER       = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] display_data,
  input  logic        update_enabled,
  output logic [31:0] displayed_data,
  output logic [6:0]  segments,
  output logic        decimal_point,
  output logic [7:0]  digit_select
);

  localparam int            CW       = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIVIDER - 1);

  logic [31:0]   latch_q, latch_d;
  logic [CW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic          tick;

  // Refresh timing is independent of loads, so the scan never stalls or
  // restarts when the word changes.
  always_comb begin
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + CW'(1);
    idx_d   = tick ? idx_q + 3'd1 : idx_q;
    latch_d = update_enabled ? display_data : latch_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      latch_q <= '0;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      latch_q <= latch_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
    end
  end

  logic [4:0]  shamt;
  logic [31:0] upper;
  logic [3:0]  nibble;
  logic        blank;

  always_comb begin
    shamt  = {idx_q, 2'b00};
    // Everything from the current nibble upward; zero means this digit is
    // a leading zero. Digit 0 is exempt so a zero word still shows "0".
    upper  = latch_q >> shamt;
    nibble = upper[3:0];
    blank  = BLANK_LEADING && (idx_q != 3'd0) && (upper == 32'd0);

    digit_select  = ~(8'b0000_0001 << idx_q);
    decimal_point = 1'b1;

    segments = 7'h7F;
    if (!blank) begin
      case (nibble)
        4'h0:    segments = 7'h40;
        4'h1:    segments = 7'h79;
        4'h2:    segments = 7'h24;
        4'h3:    segments = 7'h30;
        4'h4:    segments = 7'h19;
        4'h5:    segments = 7'h12;
        4'h6:    segments = 7'h02;
        4'h7:    segments = 7'h78;
        4'h8:    segments = 7'h00;
        4'h9:    segments = 7'h10;
        4'hA:    segments = 7'h08;
        4'hB:    segments = 7'h03;
        4'hC:    segments = 7'h46;
        4'hD:    segments = 7'h21;
        4'hE:    segments = 7'h06;
        default: segments = 7'h0E;
      endcase
    end
  end

  assign displayed_data = latch_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner with DIVIDER=4, two instances (blanking on/off).
// Directed stimulus with literal expectations plus a per-cycle model compare.
// Stimulus is driven on the falling edge; outputs are sampled on the falling edge.
module tb_hex_display_scanner;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] display_data = '0;
  logic        update_enabled = 1'b0;

  logic [31:0] dd1, dd0;
  logic [6:0]  seg1, seg0;
  logic        dp1, dp0;
  logic [7:0]  sel1, sel0;

  hex_display_scanner #(.DIVIDER(DIV), .BLANK_LEADING(1'b1)) dut1 (
    .clock(clock), .reset(reset), .display_data(display_data),
    .update_enabled(update_enabled), .displayed_data(dd1), .segments(seg1),
    .decimal_point(dp1), .digit_select(sel1));

  hex_display_scanner #(.DIVIDER(DIV), .BLANK_LEADING(1'b0)) dut0 (
    .clock(clock), .reset(reset), .display_data(display_data),
    .update_enabled(update_enabled), .displayed_data(dd0), .segments(seg0),
    .decimal_point(dp0), .digit_select(sel0));

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the digit shown is simply (cycles since reset / DIV) mod 8.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] m_latch = '0;
  int          m_cyc   = 0;
  bit          m_valid = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_latch = '0;
      m_cyc   = 0;
      m_valid = 1'b1;
    end else begin
      m_cyc++;
      if (update_enabled) m_latch = display_data;
    end
  end

  function automatic logic [6:0] exp_seg(input logic [31:0] w, input int idx, input bit blank_en);
    logic [31:0] up;
    up = w >> (4 * idx);
    if (blank_en && idx > 0 && up == 32'd0) return 7'h7F;
    return seg_tab[int'(up & 32'hF)];
  endfunction

  always @(negedge clock) begin
    if (m_valid) begin
      int idx;
      idx = (m_cyc / DIV) % 8;
      chk("model_data1", dd1, m_latch);
      chk("model_data0", dd0, m_latch);
      chk("model_sel1", {24'd0, sel1}, {24'd0, ~(8'd1 << idx)});
      chk("model_sel0", {24'd0, sel0}, {24'd0, ~(8'd1 << idx)});
      chk("model_seg1", {25'd0, seg1}, {25'd0, exp_seg(m_latch, idx, 1'b1)});
      chk("model_seg0", {25'd0, seg0}, {25'd0, exp_seg(m_latch, idx, 1'b0)});
      chk("model_dp", {30'd0, dp1, dp0}, 32'd3);
    end
  end

  logic [6:0] seq_12345678 [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [31:0] follow_vals [6] = '{32'h11111111, 32'h00000000, 32'hCAFEF00D,
                                   32'h0000F000, 32'h80000001, 32'h76543210};

  initial begin
    // Reset for two edges with a load attempted: reset must win.
    reset = 1'b1; update_enabled = 1'b1; display_data = 32'hAAAA5555;
    repeat (2) @(negedge clock);
    chk("rst_data", dd1, 32'h0);
    chk("rst_sel", {24'd0, sel1}, 32'hFE);
    chk("rst_seg", {25'd0, seg1}, 32'h40);
    chk("rst_dp", {31'd0, dp1}, 32'h1);
    reset = 1'b0; update_enabled = 1'b0; display_data = '0;

    // First dwell lasts DIV cycles, then digit 1 of a zero word.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_sel_hold", {24'd0, sel1}, 32'hFE);
    end
    @(negedge clock);
    chk("idle_sel_adv", {24'd0, sel1}, 32'hFD);
    chk("idle_seg_blank", {25'd0, seg1}, 32'h7F);
    chk("idle_seg_noblank", {25'd0, seg0}, 32'h40);

    // Full scan of 12345678.
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    update_enabled = 1'b1; display_data = 32'h12345678;
    @(negedge clock);
    update_enabled = 1'b0;
    chk("load_data", dd1, 32'h12345678);
    repeat (2) @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) repeat (DIV) @(negedge clock);
      chk("scan_sel", {24'd0, sel1}, {24'd0, ~(8'd1 << k)});
      chk("scan_seg", {25'd0, seg1}, {25'd0, seq_12345678[k]});
    end

    // 0000000A: leading-zero blanking versus full display.
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    update_enabled = 1'b1; display_data = 32'h0000000A;
    @(negedge clock);
    update_enabled = 1'b0;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) repeat (DIV) @(negedge clock);
      chk("a_seg_blank", {25'd0, seg1}, (k == 0) ? 32'h08 : 32'h7F);
      chk("a_seg_noblank", {25'd0, seg0}, (k == 0) ? 32'h08 : 32'h40);
    end

    // Next edge is the tick out of digit 7: load on the same edge.
    update_enabled = 1'b1; display_data = 32'hFFFFFFFF;
    @(negedge clock);
    update_enabled = 1'b0;
    chk("wrap_data", dd1, 32'hFFFFFFFF);
    chk("wrap_sel", {24'd0, sel1}, 32'hFE);
    chk("wrap_seg1", {25'd0, seg1}, 32'h0E);
    chk("wrap_seg0", {25'd0, seg0}, 32'h0E);

    // Strobe held high: latch follows every cycle.
    for (int j = 0; j < 6; j++) begin
      update_enabled = 1'b1; display_data = follow_vals[j];
      @(negedge clock);
      chk("follow_data", dd1, follow_vals[j]);
    end
    update_enabled = 1'b0;

    // Advance to index 5, divider 2 (22 edges into a 32-edge scan).
    repeat (16) @(negedge clock);
    chk("mid_sel", {24'd0, sel1}, 32'hDF);
    reset = 1'b1; update_enabled = 1'b1; display_data = 32'hDEADBEEF;
    @(negedge clock);
    chk("midrst_data", dd1, 32'h0);
    chk("midrst_sel", {24'd0, sel1}, 32'hFE);
    chk("midrst_seg", {25'd0, seg1}, 32'h40);
    reset = 1'b0; update_enabled = 1'b0; display_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("midrst_hold", {24'd0, sel1}, 32'hFE);
    end
    @(negedge clock);
    chk("midrst_tick", {24'd0, sel1}, 32'hFD);

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
